// File: rtl/booth_multiplier_seq.sv
// rtl/booth_multiplier_seq.sv - sequential radix-2 Booth multiplier for signed or unsigned operands
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH:0]  m_ext, acc, q_reg;
  logic [WIDTH:0]  acc_sum, acc_next, q_next;
  logic            q_m1;
  logic [CW-1:0]   count;
  logic            accept, last_step;

  // Operands carry one extra bit so unsigned values and the most-negative
  // signed value both run through the same signed Booth recurrence.
  always_comb begin
    acc_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
    acc_next = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    q_next   = {acc_sum[0], q_reg[WIDTH:1]};
  end

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (state == RUN) && (count == CW'(1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = start ? RUN : IDLE;
      RUN:        state_next = (count == CW'(1)) ? DONE : RUN;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_ext   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        m_ext <= {signed_mode & multiplicand[WIDTH-1], multiplicand};
        q_reg <= {signed_mode & multiplier[WIDTH-1], multiplier};
        acc   <= '0;
        q_m1  <= 1'b0;
        count <= STEPS;
      end else if (state == RUN) begin
        acc   <= acc_next;
        q_reg <= q_next;
        q_m1  <= q_reg[0];
        count <= count - CW'(1);
      end
      // The two top bits of the shifted {A,Q} are pure sign extension.
      if (last_step) begin
        product <= {acc_next[WIDTH-2:0], q_next};
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb/tb_booth_multiplier_seq.sv - directed and model-checked bench for booth_multiplier_seq
module tb_booth_multiplier_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start8, sm8, busy8, done8;
  logic [7:0] m8, q8;
  logic [15:0] p8;
  logic start16, sm16, busy16, done16;
  logic [15:0] m16, q16;
  logic [31:0] p16;
  logic start4, sm4, busy4, done4;
  logic [3:0] m4, q4;
  logic [7:0] p4;

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8), .product(p8), .busy(busy8), .done(done8)
  );
  booth_multiplier_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .multiplicand(m16), .multiplier(q16), .product(p16), .busy(busy16), .done(done16)
  );
  booth_multiplier_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .multiplicand(m4), .multiplier(q4), .product(p4), .busy(busy4), .done(done4)
  );

  int n_vec = 0;
  int n_fail = 0;
  logic overlap = 1'b0;

  always @(negedge clk) begin
    if ((busy8 && done8) || (busy16 && done16) || (busy4 && done4)) overlap <= 1'b1;
  end

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] m, input logic [31:0] q,
                                          input logic sm);
    longint a, b, r;
    a = longint'(m);
    b = longint'(q);
    if (sm && m[w-1]) a = a - (longint'(1) << w);
    if (sm && q[w-1]) b = b - (longint'(1) << w);
    r = a * b;
    return 64'(r) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Starts one operation on the selected instance and waits for its done pulse.
  // lat counts edges from acceptance to the edge that raised done.
  task automatic run_op(input int sel, input logic [31:0] m, input logic [31:0] q, input logic sm,
                        output logic [63:0] p, output int lat, output int nbusy);
    logic b, d;
    @(negedge clk);
    case (sel)
      8:       begin m8 = m[7:0];   q8 = q[7:0];   sm8 = sm;  start8 = 1'b1;  end
      16:      begin m16 = m[15:0]; q16 = q[15:0]; sm16 = sm; start16 = 1'b1; end
      default: begin m4 = m[3:0];   q4 = q[3:0];   sm4 = sm;  start4 = 1'b1;  end
    endcase
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0; start4 = 1'b0;
    lat = 0; nbusy = 0; p = '0; b = 1'b0; d = 1'b0;
    while (1) begin
      case (sel)
        8:       begin b = busy8;  d = done8;  p = {48'b0, p8};  end
        16:      begin b = busy16; d = done16; p = {32'b0, p16}; end
        default: begin b = busy4;  d = done4;  p = {56'b0, p4};  end
      endcase
      if (b) nbusy++;
      if (d || lat >= 40) break;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!d) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: no done within %0d cycles, expected one", lat);
    end
  endtask

  initial begin
    vec_t tbl[10];
    logic [63:0] p;
    int lat, nb, k, first, ndone;
    logic [15:0] pval;
    logic [7:0] rm, rq;

    tbl[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[3] = '{8'hFF, 8'h03, 1'b1, 16'hFFFD};
    tbl[4] = '{8'hFF, 8'h03, 1'b0, 16'h02FD};
    tbl[5] = '{8'h07, 8'h06, 1'b0, 16'h002A};
    tbl[6] = '{8'h00, 8'h5A, 1'b1, 16'h0000};
    tbl[7] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[8] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    tbl[9] = '{8'h01, 8'h80, 1'b1, 16'hFF80};

    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
    start16 = 1'b0; sm16 = 1'b0; m16 = '0; q16 = '0;
    start4 = 1'b0; sm4 = 1'b0; m4 = '0; q4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset product8", {48'b0, p8}, 64'h0);
    check("reset busy8", {63'b0, busy8}, 64'h0);
    check("reset done8", {63'b0, done8}, 64'h0);
    check("reset product16", {32'b0, p16}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(8, {24'b0, tbl[i].m}, {24'b0, tbl[i].q}, tbl[i].sm, p, lat, nb);
      check($sformatf("vec%0d product", i), p, {48'b0, tbl[i].exp});
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd9);
      if (i == 0) check("vec0 busy cycles", 64'(nb), 64'd9);
    end

    // Back-to-back with start held high; signed_mode flips after the first acceptance.
    @(negedge clk);
    m8 = 8'hFF; q8 = 8'h03; sm8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sm8 = 1'b0;
    k = 0; first = -1; ndone = 0;
    while (k < 40 && ndone < 2) begin
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          first = k;
          check("b2b signed product", {48'b0, p8}, 64'hFFFD);
        end else begin
          check("b2b unsigned product", {48'b0, p8}, 64'h02FD);
          check("b2b done spacing", 64'(k - first), 64'd10);
        end
      end
      if (ndone == 1 && k == first + 5) check("b2b product held in RUN", {48'b0, p8}, 64'hFFFD);
      if (ndone < 2) begin
        @(posedge clk);
        @(negedge clk);
        k++;
      end
    end
    start8 = 1'b0;
    check("b2b first latency", 64'(first), 64'd9);
    check("b2b done count", 64'(ndone), 64'd2);

    // start and operand changes during RUN are ignored.
    @(negedge clk);
    @(negedge clk);
    m8 = 8'h05; q8 = 8'h09; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    k = 0; ndone = 0; pval = '0;
    while (k < 30) begin
      if (k == 3) begin start8 = 1'b1; m8 = 8'h0B; q8 = 8'h0C; sm8 = 1'b1; end
      if (k == 4) begin start8 = 1'b0; m8 = 8'h33; end
      if (done8) begin ndone++; pval = p8; end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("run-start product", {48'b0, pval}, 64'h002D);
    check("run-start done count", 64'(ndone), 64'd1);

    // Reset in the 4th RUN cycle aborts without a done pulse.
    @(negedge clk);
    m8 = 8'h12; q8 = 8'h34; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {63'b0, busy8}, 64'h0);
    check("abort done", {63'b0, done8}, 64'h0);
    check("abort product", {48'b0, p8}, 64'h0);
    ndone = 0;
    repeat (15) begin
      if (done8) ndone++;
      @(posedge clk);
      @(negedge clk);
    end
    check("abort no done", 64'(ndone), 64'd0);
    run_op(8, 32'h07, 32'h06, 1'b0, p, lat, nb);
    check("post-reset product", p, 64'h002A);
    check("post-reset latency", 64'(lat), 64'd9);

    run_op(16, 32'h7FFF, 32'h8000, 1'b1, p, lat, nb);
    check("w16 7FFF*8000 product", p, 64'hC0008000);
    check("w16 latency", 64'(lat), 64'd17);
    run_op(16, 32'h8000, 32'h8000, 1'b1, p, lat, nb);
    check("w16 8000*8000 product", p, 64'h40000000);
    run_op(16, 32'hFFFF, 32'hFFFF, 1'b0, p, lat, nb);
    check("w16 FFFF*FFFF product", p, 64'hFFFE0001);

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_op(4, 32'(a), 32'(b), s[0], p, lat, nb);
          check($sformatf("w4 %0d*%0d mode%0d", a, b, s), p, ref_mul(4, 32'(a), 32'(b), s[0]));
        end
      end
    end

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 100; i++) begin
        rm = 8'($urandom);
        rq = 8'($urandom);
        run_op(8, {24'b0, rm}, {24'b0, rq}, s[0], p, lat, nb);
        check($sformatf("w8 rand %0h*%0h mode%0d", rm, rq, s), p, ref_mul(8, {24'b0, rm}, {24'b0, rq}, s[0]));
      end
    end

    check("busy/done overlap", {63'b0, overlap}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
